// File: rtl/bcd_scan_driver.sv
// Binary-to-BCD converter and 4-digit multiplexed display driver.
// A sequential double-dabble engine converts a 14-bit value (saturated at 9999)
// into four BCD digits, one bit per cycle. A free-running refresh counter then
// scans the digits onto a single BCD bus with active-low anode enables.
module bcd_scan_driver #(
    parameter int unsigned COUNT_MAX     = 50000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value,
    input  logic        load,
    output logic        busy,
    output logic        ovf,
    output logic [3:0]  BCD,
    output logic [3:0]  An
);

    localparam int unsigned CntW = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(COUNT_MAX - 1);
    localparam logic [13:0] MaxValue = 14'd9999;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [13:0]     shift_q;
    logic [15:0]     work_q;
    logic [15:0]     work_adj;
    logic [3:0]      bit_cnt_q;
    logic            ovf_q;
    logic [15:0]     digit_q;
    logic [13:0]     value_sat;

    logic [CntW-1:0] refresh_q;
    logic [1:0]      idx_q;
    logic [3:0]      bcd_q, an_q;
    logic [3:0]      bcd_d, an_d;
    logic [3:0]      digit_sel;
    logic            upper_zero;

    assign value_sat = (value > MaxValue) ? MaxValue : value;

    // Conversion FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Conversion FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (load) state_d = StShift;
            StShift: if (bit_cnt_q == 4'd0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Double-dabble correction: add 3 to any work nibble >= 5 before shifting.
    always_comb begin
        work_adj = '0;
        for (int i = 0; i < 4; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end else begin
                work_adj[4*i +: 4] = work_q[4*i +: 4];
            end
        end
    end

    // Conversion datapath: capture, shift 14 times, then publish all digits at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            work_q    <= '0;
            bit_cnt_q <= '0;
            ovf_q     <= 1'b0;
            digit_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (load) begin
                        shift_q   <= value_sat;
                        work_q    <= '0;
                        bit_cnt_q <= 4'd13;
                        ovf_q     <= (value > MaxValue);
                    end
                end
                StShift: begin
                    {work_q, shift_q} <= {work_adj, shift_q} << 1;
                    if (bit_cnt_q != 4'd0) begin
                        bit_cnt_q <= bit_cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    digit_q <= work_q;
                end
                default: ;
            endcase
        end
    end

    // Refresh counter and scan index, free-running regardless of conversion state.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_q <= '0;
            idx_q     <= '0;
        end else if (refresh_q == CntLast) begin
            refresh_q <= '0;
            idx_q     <= idx_q + 2'd1;
        end else begin
            refresh_q <= refresh_q + 1'b1;
        end
    end

    // Select the scanned digit and decide whether it is a blanked leading zero.
    always_comb begin
        digit_sel  = digit_q[4*idx_q +: 4];
        upper_zero = 1'b0;
        case (idx_q)
            2'd1:    upper_zero = (digit_q[15:4] == 12'd0);
            2'd2:    upper_zero = (digit_q[15:8] == 8'd0);
            2'd3:    upper_zero = (digit_q[15:12] == 4'd0);
            default: upper_zero = 1'b0;
        endcase
        if (BLANK_LEADING && upper_zero) begin
            an_d  = 4'b1111;
            bcd_d = 4'b0000;
        end else begin
            an_d  = ~(4'b0001 << idx_q);
            bcd_d = digit_sel;
        end
    end

    // Registered display outputs, one cycle behind the scan index.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= 4'b1111;
            bcd_q <= 4'b0000;
        end else begin
            an_q  <= an_d;
            bcd_q <= bcd_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign ovf  = ovf_q;
    assign BCD  = bcd_q;
    assign An   = an_q;

endmodule
